// File: rtl/aplic_pkg.sv
// Shared types and constants for the APLIC MSI delivery path.
//   msi_sched_state_e : MSI scheduler FSM states
//   AXI_RESP_OKAY     : AXI B-channel OKAY response code
//   MsiDataW          : width of an MSI write payload
package aplic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } msi_sched_state_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam int unsigned MsiDataW = 32;

endpackage

// File: rtl/aplic_rr_arbiter.sv
// Round-robin arbiter for domain-shared resources.
// Grants the first set request at or after ptr, wrapping around.
//   req     : request vector
//   en      : grant enable; no grant is issued while low
//   ptr     : highest-priority index for this cycle
//   gnt     : one-hot grant (all zero when nothing is granted)
//   gnt_idx : index of the granted request (0 when nothing is granted)
module aplic_rr_arbiter #(
  parameter int unsigned NrReq = 2,
  localparam int unsigned IdxW = (NrReq > 1) ? $clog2(NrReq) : 1
) (
  input  logic [NrReq-1:0] req,
  input  logic             en,
  input  logic [IdxW-1:0]  ptr,
  output logic [NrReq-1:0] gnt,
  output logic [IdxW-1:0]  gnt_idx
);

  // Scan from ptr upwards; the first hit wins.
  always_comb begin
    int unsigned k;
    logic        found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = 0;
    for (int unsigned i = 0; i < NrReq; i++) begin
      k = (32'(ptr) + i) % NrReq;
      if (en && !found && req[IdxW'(k)]) begin
        found           = 1'b1;
        gnt[IdxW'(k)]   = 1'b1;
        gnt_idx         = IdxW'(k);
      end
    end
  end

endmodule

// File: rtl/aplic_msi_scheduler.sv
// Sequences MSI writes from the APLIC interrupt domains onto one shared AXI
// write port. Domains are served round-robin; one AW/W/B transaction is in
// flight at a time.
//   i_clk, i_rst                 : clock, async active-high reset
//   i_req_valid/hart/eiid        : per-domain MSI requests (held until ready)
//   o_req_ready                  : one-hot combinational accept pulse
//   o_aw_*, o_w_*, i_b_*, o_b_ready : AXI write master channels
//   o_done, o_err, o_done_domain : completion / error pulse and its domain
//   o_busy                       : a write is in flight
module aplic_msi_scheduler
  import aplic_pkg::*;
#(
  parameter int unsigned      NrDomains    = 2,
  parameter int unsigned      HartIdxW     = 14,
  parameter int unsigned      NrHarts      = 4,
  parameter int unsigned      EiidW        = 11,
  parameter int unsigned      AddrW        = 64,
  parameter logic [AddrW-1:0] BaseAddr     = 'h2400_0000,
  parameter logic [AddrW-1:0] DomainStride = 'h0100_0000,
  parameter int unsigned      HartShift    = 12,
  localparam int unsigned     DomW         = (NrDomains > 1) ? $clog2(NrDomains) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NrDomains-1:0]          i_req_valid,
  input  logic [NrDomains*HartIdxW-1:0] i_req_hart,
  input  logic [NrDomains*EiidW-1:0]    i_req_eiid,
  output logic [NrDomains-1:0]          o_req_ready,
  output logic                          o_aw_valid,
  input  logic                          i_aw_ready,
  output logic [AddrW-1:0]              o_aw_addr,
  output logic                          o_w_valid,
  input  logic                          i_w_ready,
  output logic [MsiDataW-1:0]           o_w_data,
  output logic [3:0]                    o_w_strb,
  output logic                          o_w_last,
  input  logic                          i_b_valid,
  input  logic [1:0]                    i_b_resp,
  output logic                          o_b_ready,
  output logic                          o_done,
  output logic                          o_err,
  output logic [DomW-1:0]               o_done_domain,
  output logic                          o_busy
);

  msi_sched_state_e state_q, state_d;

  logic [DomW-1:0]      ptr_q, ptr_d;
  logic [DomW-1:0]      dom_q, dom_d;
  logic [NrDomains-1:0] gnt;
  logic [DomW-1:0]      gnt_idx;
  logic [HartIdxW-1:0]  hart_arr [NrDomains];
  logic [EiidW-1:0]     eiid_arr [NrDomains];
  logic [HartIdxW-1:0]  sel_hart;
  logic [EiidW-1:0]     sel_eiid;
  logic                 hart_bad;
  logic [AddrW-1:0]     grant_addr;

  logic                 aw_valid_d, w_valid_d, b_ready_d;
  logic                 done_d, err_d;
  logic [DomW-1:0]      done_dom_d;
  logic [AddrW-1:0]     addr_d;
  logic [MsiDataW-1:0]  data_d;

  assign o_w_strb = 4'hF;
  assign o_w_last = 1'b1;

  // Unpack the flat per-domain request buses.
  for (genvar d = 0; d < NrDomains; d++) begin : g_unpack
    assign hart_arr[d] = i_req_hart[d*HartIdxW +: HartIdxW];
    assign eiid_arr[d] = i_req_eiid[d*EiidW +: EiidW];
  end

  // Grants only in IDLE; gated by reset so ready reads 0 while in reset.
  aplic_rr_arbiter #(
    .NrReq(NrDomains)
  ) u_arb (
    .req    (i_req_valid),
    .en     ((state_q == IDLE) && !i_rst),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_idx(gnt_idx)
  );

  assign o_req_ready = gnt;
  assign sel_hart    = hart_arr[gnt_idx];
  assign sel_eiid    = eiid_arr[gnt_idx];
  assign hart_bad    = (64'(sel_hart) >= 64'(NrHarts));

  // IMSIC target: per-domain file region plus per-hart page, wrapping mod 2^AddrW.
  assign grant_addr = BaseAddr
                    + (AddrW'(gnt_idx) * DomainStride)
                    + (AddrW'(sel_hart) << HartShift);

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    dom_d      = dom_q;
    aw_valid_d = o_aw_valid;
    w_valid_d  = o_w_valid;
    b_ready_d  = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    done_dom_d = o_done_domain;
    addr_d     = o_aw_addr;
    data_d     = o_w_data;

    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          ptr_d = (gnt_idx == DomW'(NrDomains - 1)) ? '0 : gnt_idx + DomW'(1);
          dom_d = gnt_idx;
          if (sel_eiid == '0) begin
            // EIID 0 is "no interrupt": consume silently.
          end else if (hart_bad) begin
            err_d      = 1'b1;
            done_dom_d = gnt_idx;
          end else begin
            state_d    = ADDR;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            addr_d     = grant_addr;
            data_d     = MsiDataW'(sel_eiid);
          end
        end
      end

      ADDR: begin
        // AW and W retire independently; advance once both have.
        if (i_aw_ready) aw_valid_d = 1'b0;
        if (i_w_ready)  w_valid_d  = 1'b0;
        if (!aw_valid_d && !w_valid_d) begin
          state_d   = RESP;
          b_ready_d = 1'b1;
        end
      end

      RESP: begin
        if (i_b_valid) begin
          state_d    = IDLE;
          done_d     = 1'b1;
          err_d      = (i_b_resp != AXI_RESP_OKAY);
          done_dom_d = dom_q;
        end else begin
          b_ready_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      dom_q         <= '0;
      o_aw_valid    <= 1'b0;
      o_w_valid     <= 1'b0;
      o_b_ready     <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
      o_done_domain <= '0;
      o_aw_addr     <= '0;
      o_w_data      <= '0;
      o_busy        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      dom_q         <= dom_d;
      o_aw_valid    <= aw_valid_d;
      o_w_valid     <= w_valid_d;
      o_b_ready     <= b_ready_d;
      o_done        <= done_d;
      o_err         <= err_d;
      o_done_domain <= done_dom_d;
      o_aw_addr     <= addr_d;
      o_w_data      <= data_d;
      o_busy        <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_aplic_msi_scheduler.sv
// Scoreboard bench for aplic_msi_scheduler: request drivers and an AXI slave
// feed the DUT; a negedge monitor predicts grants with its own round-robin
// model and checks every AW/W/B beat and completion pulse.
module tb_aplic_msi_scheduler;

  localparam int ND = 2;
  localparam int HW = 14;
  localparam int NH = 4;
  localparam int EW = 11;

  typedef struct {
    logic [HW-1:0] hart;
    logic [EW-1:0] eiid;
  } stim_t;

  typedef struct {
    int          dom;
    bit          wr;
    logic [63:0] addr;
    logic [31:0] data;
    int          gcyc;
  } exp_t;

  logic              clk, rst;
  logic [ND-1:0]     req_valid;
  logic [ND*HW-1:0]  req_hart;
  logic [ND*EW-1:0]  req_eiid;
  logic [ND-1:0]     o_req_ready;
  logic              o_aw_valid, aw_ready;
  logic [63:0]       o_aw_addr;
  logic              o_w_valid, w_ready;
  logic [31:0]       o_w_data;
  logic [3:0]        o_w_strb;
  logic              o_w_last;
  logic              b_valid;
  logic [1:0]        b_resp;
  logic              o_b_ready, o_done, o_err, o_busy;
  logic [0:0]        o_done_domain;

  logic [HW-1:0] hart_a [ND];
  logic [EW-1:0] eiid_a [ND];
  stim_t         stim_q [ND][$];
  exp_t          sb[$];
  int            glog[$];
  logic [ND-1:0] acc;

  int checks = 0, passed = 0;
  int cyc = 0;
  int model_ptr = 0;
  bit outstanding = 0;
  bit aw_seen, w_seen;
  int aw_cyc, w_cyc;
  logic [1:0] b_resp_seen;
  int last_lat;
  bit both_pulse;
  int drop_cnt = 0, aw_total = 0, acc_cnt = 0;

  // slave configuration
  bit rnd = 0, gap_en = 0;
  int aw_delay = 0, w_delay = 0;
  logic [1:0] fixed_resp = 2'b00;
  int aw_wait, w_wait;

  aplic_msi_scheduler dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .i_req_hart   (req_hart),
    .i_req_eiid   (req_eiid),
    .o_req_ready  (o_req_ready),
    .o_aw_valid   (o_aw_valid),
    .i_aw_ready   (aw_ready),
    .o_aw_addr    (o_aw_addr),
    .o_w_valid    (o_w_valid),
    .i_w_ready    (w_ready),
    .o_w_data     (o_w_data),
    .o_w_strb     (o_w_strb),
    .o_w_last     (o_w_last),
    .i_b_valid    (b_valid),
    .i_b_resp     (b_resp),
    .o_b_ready    (o_b_ready),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_done_domain(o_done_domain),
    .o_busy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always_comb begin
    for (int d = 0; d < ND; d++) begin
      req_hart[d*HW +: HW] = hart_a[d];
      req_eiid[d*EW +: EW] = eiid_a[d];
    end
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void fail(string name);
    checks++;
    $display("FAIL %s: condition violated (cycle %0d)", name, cyc);
  endfunction

  // Reference: IMSIC page address of hart h in domain d.
  function automatic logic [63:0] exp_addr(int d, int h);
    return 64'h2400_0000 + 64'(d) * 64'h0100_0000 + (64'(h) << 12);
  endfunction

  function automatic int rr_pick(logic [ND-1:0] v, int p);
    for (int i = 0; i < ND; i++) begin
      int k = (p + i) % ND;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic push(int d, int h, int e);
    stim_t s;
    s.hart = HW'(h);
    s.eiid = EW'(e);
    stim_q[d].push_back(s);
  endtask

  // Request drivers: present the next queued request once the previous one is accepted.
  initial begin
    req_valid = '0;
    acc = '0;
    for (int d = 0; d < ND; d++) begin hart_a[d] = '0; eiid_a[d] = '0; end
    forever begin
      @(posedge clk); #1;
      for (int d = 0; d < ND; d++) begin
        if (acc[d]) begin req_valid[d] = 1'b0; acc[d] = 1'b0; end
        if (rst) req_valid[d] = 1'b0;
        else if (!req_valid[d] && stim_q[d].size() > 0 && !(gap_en && ($urandom % 3 == 0))) begin
          stim_t s;
          s = stim_q[d].pop_front();
          hart_a[d] = s.hart;
          eiid_a[d] = s.eiid;
          req_valid[d] = 1'b1;
        end
      end
    end
  end

  // AXI slave.
  initial begin
    aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = 0; aw_wait = 0; w_wait = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        aw_ready = 0; w_ready = 0; b_valid = 0; aw_wait = 0; w_wait = 0;
      end else begin
        if (o_aw_valid) begin
          aw_ready = rnd ? 1'($urandom % 2) : (aw_wait >= aw_delay);
          aw_wait++;
        end else begin aw_ready = 0; aw_wait = 0; end
        if (o_w_valid) begin
          w_ready = rnd ? 1'($urandom % 2) : (w_wait >= w_delay);
          w_wait++;
        end else begin w_ready = 0; w_wait = 0; end
        if (o_b_ready) begin
          if (!b_valid && (!rnd || ($urandom % 2 == 0))) begin
            b_valid = 1'b1;
            b_resp  = rnd ? 2'($urandom % 4) : fixed_resp;
          end
        end else b_valid = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  exp_t mon_e;
  int   mg, ag;
  always @(negedge clk) begin
    if (!rst) begin
      if (o_done || o_err) begin
        if (sb.size() == 0) fail("spurious_pulse");
        else begin
          mon_e = sb.pop_front();
          both_pulse = o_done && o_err;
          chk("pulse_is_done", o_done, mon_e.wr);
          chk("pulse_domain", o_done_domain, mon_e.dom);
          if (mon_e.wr) begin
            chk("pulse_err", o_err, b_resp_seen != 2'b00);
            chk("done_after_aw_w", aw_seen && w_seen, 1);
            last_lat = cyc - mon_e.gcyc;
            outstanding = 0;
          end else begin
            chk("drop_err", o_err, 1);
            drop_cnt++;
          end
        end
      end

      chk("busy", o_busy, outstanding);
      chk("ready_onehot", $countones(o_req_ready) <= 1, 1);

      if (|o_req_ready) begin
        mg = rr_pick(req_valid, model_ptr);
        ag = 0;
        for (int d = 0; d < ND; d++) if (o_req_ready[d]) ag = d;
        chk("grant_domain", o_req_ready, (mg < 0) ? 0 : (1 << mg));
        if (outstanding) fail("grant_while_busy");
        acc = acc | o_req_ready;
        acc_cnt++;
        glog.push_back(ag);
        if (mg >= 0) begin
          model_ptr = (mg + 1) % ND;
          if (eiid_a[mg] != 0) begin
            mon_e.dom  = mg;
            mon_e.wr   = (hart_a[mg] < NH);
            mon_e.addr = exp_addr(mg, int'(hart_a[mg]));
            mon_e.data = 32'(eiid_a[mg]);
            mon_e.gcyc = cyc;
            sb.push_back(mon_e);
            if (mon_e.wr) begin
              outstanding = 1; aw_seen = 0; w_seen = 0; aw_cyc = 0; w_cyc = 0;
            end
          end
        end
      end else if (!outstanding && |req_valid) fail("missing_grant");

      if (o_busy) begin
        if (sb.size() == 0 || !sb[0].wr) fail("busy_without_write");
        else begin
          chk("aw_addr", o_aw_addr, sb[0].addr);
          chk("w_data", o_w_data, 64'(sb[0].data));
        end
      end
      if (o_aw_valid) begin
        aw_cyc++;
        if (aw_seen) fail("aw_valid_after_hs");
        if (aw_ready) begin aw_seen = 1; aw_total++; end
      end
      if (o_w_valid) begin
        w_cyc++;
        chk("w_strb_last", {o_w_strb, o_w_last}, 5'h1F);
        if (w_seen) fail("w_valid_after_hs");
        if (w_ready) w_seen = 1;
      end
      if (o_b_ready) begin
        chk("resp_after_hs", aw_seen && w_seen && !o_aw_valid && !o_w_valid, 1);
        if (b_valid) b_resp_seen = b_resp;
      end
    end
  end

  task automatic wait_quiet();
    int n = 0;
    while (stim_q[0].size() + stim_q[1].size() != 0 || req_valid != 0 || sb.size() != 0 || o_busy) begin
      @(negedge clk);
      n++;
      if (n > 20000) begin fail("timeout"); break; end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_ctrl"}, {o_aw_valid, o_w_valid, o_b_ready, o_done, o_err, o_busy, o_req_ready}, 0);
    chk({tag, "_addr"}, o_aw_addr, 0);
    chk({tag, "_data"}, o_w_data, 0);
    chk({tag, "_dom"}, o_done_domain, 0);
  endtask

  initial begin
    int n, d0, a0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk); #2 rst = 1'b0;

    // single request, all readies immediate
    push(1, 2, 5);
    wait_quiet();
    chk("single_latency", last_lat, 3);
    chk("single_aw_cycles", aw_cyc, 1);

    // both domains continuously valid
    glog.delete();
    for (int i = 0; i < 4; i++) begin push(0, i, 10 + i); push(1, 3 - i, 20 + i); end
    wait_quiet();
    chk("alt_count", glog.size(), 8);
    for (int i = 0; i < 4 && i < glog.size(); i++) chk("alt_grant", glog[i], i % 2);

    // AW delayed, W immediate; then the reverse
    aw_delay = 4; w_delay = 0;
    push(0, 1, 3);
    wait_quiet();
    chk("awdly_aw_cycles", aw_cyc, 5);
    chk("awdly_w_cycles", w_cyc, 1);
    aw_delay = 0; w_delay = 4;
    push(1, 0, 2047);
    wait_quiet();
    chk("wdly_aw_cycles", aw_cyc, 1);
    chk("wdly_w_cycles", w_cyc, 5);
    w_delay = 0;

    // SLVERR response
    fixed_resp = 2'b10;
    push(1, 3, 9);
    wait_quiet();
    chk("slverr_both_pulse", both_pulse, 1);
    fixed_resp = 2'b00;

    // bad hart and EIID 0
    d0 = drop_cnt; a0 = aw_total;
    push(0, NH, 7);
    wait_quiet();
    chk("badhart_drop", drop_cnt - d0, 1);
    chk("badhart_no_aw", aw_total - a0, 0);
    d0 = drop_cnt; n = acc_cnt;
    push(1, 1, 0);
    wait_quiet();
    chk("eiid0_accepted", acc_cnt - n, 1);
    chk("eiid0_no_pulse", drop_cnt - d0, 0);
    chk("eiid0_no_aw", aw_total - a0, 0);

    // reset during ADDR with AW pending
    aw_delay = 30;
    push(0, 1, 4);
    n = 0;
    while (!o_aw_valid && n < 50) begin @(negedge clk); n++; end
    chk("rst_aw_pending", o_aw_valid, 1);
    @(negedge clk); #2 rst = 1'b1;
    #1 chk_all_zero("midrst");
    sb.delete(); glog.delete();
    model_ptr = 0; outstanding = 0;
    stim_q[0].delete(); stim_q[1].delete();
    repeat (2) @(negedge clk);
    aw_delay = 0;
    #2 rst = 1'b0;
    push(1, 0, 6); push(0, 2, 8);
    wait_quiet();
    chk("post_rst_grants", glog.size(), 2);
    if (glog.size() > 0) chk("post_rst_first", glog[0], 0);

    // randomized traffic
    rnd = 1; gap_en = 1;
    for (int i = 0; i < 300; i++) begin
      int e;
      e = ($urandom % 6 == 0) ? 0 : int'($urandom_range(1, 2047));
      push(int'($urandom % ND), int'($urandom_range(0, 5)), e);
    end
    wait_quiet();
    chk("final_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
